sw_dispatch: RTL and testbench

- Scheduler between the DMA read/write data ports and a pool of NUM_ENG Smith-Waterman scoring engines.
- Pops 512-bit sequence records from the DMA read port and issues each to a free engine, round-robin.
- Collects per-engine scores, packs them with record IDs into 512-bit result lines and pushes them to the DMA write port.
- Asserts done once all job records are scored and written.

---
 rtl/sw_dispatch_pkg.sv | 29 ++
 rtl/sw_dispatch_rr_pick.sv | 31 +++
 rtl/sw_dispatch.sv | 193 +++++++++++++++++++
 tb/tb_sw_dispatch.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_dispatch_pkg.sv
// Shared definitions for the Smith-Waterman dispatcher:
// record field offsets, result line geometry, FSM encoding.
package sw_pkg;

  localparam int REC_W   = 512;
  localparam int ID_LSB  = 0;
  localparam int ID_MSB  = 31;
  localparam int LEN_LSB = 32;
  localparam int LEN_MSB = 47;
  localparam int SEQ_LSB = 48;
  localparam int SEQ_MSB = 511;

  localparam int ID_W    = 32;
  localparam int LEN_W   = 16;
  localparam int SEQ_W   = 464;
  localparam int SCORE_W = 16;

  localparam int RES_ENTRY_W  = 32;
  localparam int RES_PER_LINE = 16;
  localparam int SLOT_W       = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } sw_state_e;

endpackage

// File: rtl/sw_dispatch_rr_pick.sv
// Round-robin picker: first set request at or after ptr.
// Ports: req, ptr in; one-hot gnt, its index idx, any out.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = W'(j);
      end
    end
  end

endmodule

// File: rtl/sw_dispatch.sv
// Dispatcher between DMA read/write ports and NUM_ENG SW engines.
// Ports: ha_pclock, reset (sync, low), start/num_records job
// control; rd_* record pop; eng_* issue/collect; wr_* result
// lines; done, records_done status. SW_DISPATCH_PERF_EN adds
// perf_busy_cycles and perf_stall_cycles.
import sw_pkg::*;

module sw_dispatch #(
  parameter int NUM_ENG   = 4,
  parameter int ENG_IDX_W = 2
) (
  input  logic                    ha_pclock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [31:0]             num_records,
  input  logic                    rd_data_ready,
  input  logic [REC_W-1:0]        rd_data,
  output logic                    rd_data_ack,
  output logic [NUM_ENG-1:0]      eng_start,
  output logic [LEN_W-1:0]        eng_length,
  output logic [SEQ_W-1:0]        eng_sequence,
  input  logic [NUM_ENG-1:0]      eng_busy,
  input  logic [NUM_ENG-1:0]      eng_valid,
  input  logic [16*NUM_ENG-1:0]   eng_result,
  output logic [NUM_ENG-1:0]      eng_res_ack,
  input  logic                    wr_data_ready,
  output logic [REC_W-1:0]        wr_data,
  output logic                    wr_data_ack,
`ifdef SW_DISPATCH_PERF_EN
  output logic [31:0]             perf_busy_cycles,
  output logic [31:0]             perf_stall_cycles,
`endif
  output logic                    done,
  output logic [31:0]             records_done
);

  sw_state_e            state;
  logic [31:0]          num_q;
  logic [31:0]          issued_q;
  logic [SLOT_W-1:0]    slot_q;
  logic [REC_W-1:0]     line_q;
  logic [NUM_ENG-1:0]   last_start_q;
  logic [ENG_IDX_W-1:0] iss_ptr_q;
  logic [ENG_IDX_W-1:0] col_ptr_q;
  logic [ID_W-1:0]      id_q [NUM_ENG];

  logic [NUM_ENG-1:0]   free;
  logic [NUM_ENG-1:0]   iss_gnt;
  logic [NUM_ENG-1:0]   col_gnt;
  logic [ENG_IDX_W-1:0] iss_idx;
  logic [ENG_IDX_W-1:0] col_idx;
  logic                 iss_any;
  logic                 col_any;
  logic                 run;
  logic                 want_rec;
  logic                 do_issue;
  logic                 do_col;
  logic                 do_wr;
  logic                 line_full;
  logic                 line_rdy;
  logic                 start_ok;
  logic [RES_ENTRY_W-1:0] entry;

  function automatic logic [ENG_IDX_W-1:0] nxt(
    input logic [ENG_IDX_W-1:0] i
  );
    if (int'(i) == NUM_ENG - 1) return '0;
    return i + 1'b1;
  endfunction

  // An engine issued last cycle may not show busy yet.
  assign free = ~eng_busy & ~eng_valid & ~last_start_q;

  rr_pick #(.N(NUM_ENG), .W(ENG_IDX_W)) u_iss (
    .req (free),
    .ptr (iss_ptr_q),
    .gnt (iss_gnt),
    .idx (iss_idx),
    .any (iss_any)
  );

  rr_pick #(.N(NUM_ENG), .W(ENG_IDX_W)) u_col (
    .req (eng_valid),
    .ptr (col_ptr_q),
    .gnt (col_gnt),
    .idx (col_idx),
    .any (col_any)
  );

  assign run       = (state == ST_RUN);
  assign want_rec  = run && rd_data_ready
                   && (issued_q < num_q);
  assign do_issue  = reset && want_rec && iss_any;
  assign line_full = (slot_q == SLOT_W'(RES_PER_LINE));
  // A full line blocks collection until it is written.
  assign do_col    = reset && run && !line_full && col_any;
  assign line_rdy  = line_full
                   || (state == ST_FLUSH && slot_q != '0);
  assign do_wr     = reset && line_rdy && wr_data_ready;
  assign start_ok  = start
                   && (state == ST_IDLE || state == ST_DONE);

  assign entry = {id_q[col_idx][ID_MSB:16],
                  eng_result[{col_idx, 4'b0} +: SCORE_W]};

  assign rd_data_ack  = do_issue;
  assign eng_start    = do_issue ? iss_gnt : '0;
  assign eng_res_ack  = do_col ? col_gnt : '0;
  assign wr_data_ack  = do_wr;
  assign wr_data      = line_rdy ? line_q : '0;
  assign eng_length   = run ? rd_data[LEN_MSB:LEN_LSB] : '0;
  assign eng_sequence = run ? rd_data[SEQ_MSB:SEQ_LSB] : '0;

  always_ff @(posedge ha_pclock) begin
    if (!reset) begin
      state        <= ST_IDLE;
      num_q        <= '0;
      issued_q     <= '0;
      slot_q       <= '0;
      line_q       <= '0;
      last_start_q <= '0;
      iss_ptr_q    <= '0;
      col_ptr_q    <= '0;
      done         <= 1'b0;
      records_done <= '0;
      for (int k = 0; k < NUM_ENG; k++) id_q[k] <= '0;
    end else begin
      last_start_q <= eng_start;
      if (do_issue) begin
        issued_q        <= issued_q + 1;
        iss_ptr_q       <= nxt(iss_idx);
        id_q[iss_idx]   <= rd_data[ID_MSB:ID_LSB];
      end
      if (do_col) begin
        line_q[{slot_q[3:0], 5'd0} +: RES_ENTRY_W] <= entry;
        slot_q       <= slot_q + 1'b1;
        records_done <= records_done + 1;
        col_ptr_q    <= nxt(col_idx);
      end else if (do_wr) begin
        line_q <= '0;
        slot_q <= '0;
      end
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state        <= ST_RUN;
            num_q        <= num_records;
            issued_q     <= '0;
            records_done <= '0;
            done         <= 1'b0;
          end
        end
        ST_RUN: begin
          if (records_done == num_q) begin
            if (slot_q == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (slot_q == '0 || do_wr) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SW_DISPATCH_PERF_EN
  always_ff @(posedge ha_pclock) begin
    if (!reset) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else if (start_ok) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if ((run || state == ST_FLUSH)
          && perf_busy_cycles != '1)
        perf_busy_cycles <= perf_busy_cycles + 1;
      if (want_rec && !iss_any
          && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 1;
    end
  end
`endif

endmodule

// File: tb/tb_sw_dispatch.sv
// Scoreboard bench for sw_dispatch with behavioural engine
// models, random records/latencies and a line-packing model.
module tb_sw_dispatch;

  localparam int NE = 4;

  logic           ha_pclock = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [31:0]    num_records = '0;
  logic           rd_data_ready = 1'b0;
  logic [511:0]   rd_data = '0;
  logic           rd_data_ack;
  logic [NE-1:0]  eng_start;
  logic [15:0]    eng_length;
  logic [463:0]   eng_sequence;
  logic [NE-1:0]  eng_busy = '0;
  logic [NE-1:0]  eng_valid = '0;
  logic [16*NE-1:0] eng_result = '0;
  logic [NE-1:0]  eng_res_ack;
  logic           wr_data_ready = 1'b0;
  logic [511:0]   wr_data;
  logic           wr_data_ack;
  logic           done;
  logic [31:0]    records_done;
`ifdef SW_DISPATCH_PERF_EN
  logic [31:0]    perf_busy_cycles;
  logic [31:0]    perf_stall_cycles;
`endif

  sw_dispatch #(.NUM_ENG(NE), .ENG_IDX_W(2)) dut (
    .ha_pclock     (ha_pclock),
    .reset         (reset),
    .start         (start),
    .num_records   (num_records),
    .rd_data_ready (rd_data_ready),
    .rd_data       (rd_data),
    .rd_data_ack   (rd_data_ack),
    .eng_start     (eng_start),
    .eng_length    (eng_length),
    .eng_sequence  (eng_sequence),
    .eng_busy      (eng_busy),
    .eng_valid     (eng_valid),
    .eng_result    (eng_result),
    .eng_res_ack   (eng_res_ack),
    .wr_data_ready (wr_data_ready),
    .wr_data       (wr_data),
    .wr_data_ack   (wr_data_ack),
`ifdef SW_DISPATCH_PERF_EN
    .perf_busy_cycles  (perf_busy_cycles),
    .perf_stall_cycles (perf_stall_cycles),
`endif
    .done          (done),
    .records_done  (records_done)
  );

  always #5 ha_pclock = ~ha_pclock;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string name, logic [511:0] act,
                     logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // engine models
  bit          pend [NE];
  bit          busy_m [NE];
  bit          fin_m [NE];
  int          cnt [NE];
  logic [31:0] eid [NE];
  logic [15:0] escore [NE];
  bit          hold = 0;
  bit          fixed_score = 0;
  int          lat_min = 3;
  int          lat_max = 3;
  int          rd_rate = 100;
  int          wr_rate = 100;

  // dispatcher reference state
  logic [NE-1:0] last_iss = '0;
  int            iptr = 0;
  int            cptr = 0;
  bit            active = 0;
  int            job_num = 0;
  int            issued = 0;
  int            collected = 0;
  int            rec_seq = 1;
  int            rd_acks = 0;
  bit            need_rec = 1;
  logic [511:0]  cur_rec = '0;
  logic [511:0]  cur_line = '0;
  int            lf = 0;
  logic [511:0]  exp_q [$];
  int            lines_written = 0;
  int            iss_ids [$];
  int            iss_eng [$];
  int            id_cnt [int];

  function automatic int pick(logic [NE-1:0] req, int p);
    for (int i = 0; i < NE; i++)
      if (req[(p + i) % NE]) return (p + i) % NE;
    return -1;
  endfunction

  task automatic sample();
    int ei;
    int ec;
    logic [NE-1:0] v;
    logic [NE-1:0] fr;
    fr = ~eng_busy & ~eng_valid & ~last_iss;
    ei = -1;
    if (active && rd_data_ready && issued < job_num)
      ei = pick(fr, iptr);
    ec = (lf < 16) ? pick(eng_valid, cptr) : -1;
    v = '0;
    if (ei >= 0) v[ei] = 1'b1;
    chk("rd_data_ack", rd_data_ack, ei >= 0);
    chk("eng_start", eng_start, v);
    v = '0;
    if (ec >= 0) v[ec] = 1'b1;
    chk("eng_res_ack", eng_res_ack, v);
    for (int k = 0; k < NE; k++) begin
      if (pend[k]) begin
        pend[k] = 0;
        busy_m[k] = 1;
      end else if (busy_m[k]) begin
        cnt[k]--;
        if (cnt[k] <= 0) begin
          busy_m[k] = 0;
          fin_m[k] = 1;
        end
      end
    end
    last_iss = '0;
    if (ei >= 0) begin
      chk("eng_length", eng_length, cur_rec[47:32]);
      chk("eng_sequence", eng_sequence, cur_rec[511:48]);
      last_iss[ei] = 1'b1;
      pend[ei] = 1;
      cnt[ei] = $urandom_range(lat_max, lat_min);
      eid[ei] = cur_rec[31:0];
      escore[ei] = fixed_score ? 16'(100 + ei)
                               : 16'($urandom);
      iss_ids.push_back(int'(cur_rec[31:16]));
      iss_eng.push_back(ei);
      issued++;
      rd_acks++;
      iptr = (ei + 1) % NE;
      need_rec = 1;
    end
    if (lf == 16 && wr_data_ready) begin
      lf = 0;
      cur_line = '0;
    end
    if (ec >= 0) begin
      cur_line[lf*32 +: 32] = {eid[ec][31:16], escore[ec]};
      lf++;
      collected++;
      fin_m[ec] = 0;
      cptr = (ec + 1) % NE;
      if (lf == 16) begin
        exp_q.push_back(cur_line);
      end else if (collected == job_num) begin
        exp_q.push_back(cur_line);
        lf = 0;
        cur_line = '0;
      end
    end
  endtask

  task automatic apply();
    for (int k = 0; k < NE; k++) begin
      eng_busy[k]  = busy_m[k] | (fin_m[k] & hold);
      eng_valid[k] = fin_m[k] & ~hold;
      eng_result[16*k +: 16] = escore[k];
    end
    if (need_rec) begin
      for (int w = 0; w < 16; w++)
        cur_rec[32*w +: 32] = $urandom;
      cur_rec[31:16] = 16'(rec_seq);
      rec_seq++;
      need_rec = 0;
    end
    rd_data = cur_rec;
    rd_data_ready = ($urandom_range(99, 0) < rd_rate);
    wr_data_ready = ($urandom_range(99, 0) < wr_rate);
  endtask

  task automatic cycle();
    @(negedge ha_pclock);
    if (reset) sample();
    @(posedge ha_pclock);
    #1;
    apply();
  endtask

  task automatic model_reset();
    for (int k = 0; k < NE; k++) begin
      pend[k] = 0;
      busy_m[k] = 0;
      fin_m[k] = 0;
      cnt[k] = 0;
      escore[k] = '0;
      eid[k] = '0;
    end
    last_iss = '0;
    iptr = 0;
    cptr = 0;
    active = 0;
    lf = 0;
    cur_line = '0;
    exp_q.delete();
    eng_busy = '0;
    eng_valid = '0;
  endtask

  task automatic job_begin(int n);
    job_num = n;
    issued = 0;
    collected = 0;
    active = 1;
    rd_acks = 0;
    lines_written = 0;
    iss_ids.delete();
    iss_eng.delete();
    id_cnt.delete();
  endtask

  task automatic start_job(int n);
    start = 1'b1;
    num_records = n;
    cycle();
    start = 1'b0;
    job_begin(n);
  endtask

  task automatic wait_done(int n);
    int b;
    b = 0;
    while (!done && b < 5000) begin
      cycle();
      b++;
    end
    chk("done_in_time", done, 1);
    chk("records_done", records_done, n);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic check_ids();
    chk("distinct_ids", id_cnt.size(), iss_ids.size());
    foreach (iss_ids[i])
      chk("id_once", id_cnt.exists(iss_ids[i])
                     ? id_cnt[iss_ids[i]] : 0, 1);
  endtask

  task automatic check_idle_outputs(string tag);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_records_done"}, records_done, 0);
    chk({tag, "_rd_ack"}, rd_data_ack, 0);
    chk({tag, "_eng_start"}, eng_start, 0);
    chk({tag, "_res_ack"}, eng_res_ack, 0);
    chk({tag, "_wr_ack"}, wr_data_ack, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_eng_length"}, eng_length, 0);
  endtask

  // write-side monitor
  always @(negedge ha_pclock) begin
    logic [511:0] e;
    if (reset && wr_data_ack) begin
      chk("wr_ack_with_ready", wr_data_ready, 1);
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_data", wr_data, e);
        lines_written++;
        for (int s = 0; s < 16; s++)
          if (wr_data[32*s +: 32] != '0) begin
            if (id_cnt.exists(int'(wr_data[32*s+16 +: 16])))
              id_cnt[int'(wr_data[32*s+16 +: 16])]++;
            else
              id_cnt[int'(wr_data[32*s+16 +: 16])] = 1;
          end
      end
    end
  end

  initial begin
    model_reset();
    reset = 1'b0;
    cycle();
    cycle();
    model_reset();
    reset = 1'b1;
    check_idle_outputs("reset");

    // four records, fixed scores 100..103
    fixed_score = 1;
    lat_min = 3;
    lat_max = 3;
    start_job(4);
    wait_done(4);
    chk("t1_rd_acks", rd_acks, 4);
    chk("t1_lines", lines_written, 1);
    foreach (iss_eng[i]) chk("t1_issue_order", iss_eng[i], i);
    check_ids();

    // empty job: done two cycles after start
    start_job(0);
    chk("t2_done_cleared", done, 0);
    cycle();
    chk("t2_done", done, 1);
    chk("t2_records_done", records_done, 0);
    repeat (3) cycle();
    chk("t2_rd_acks", rd_acks, 0);
    chk("t2_lines", lines_written, 0);

    // 40 records, random latency and back-pressure
    fixed_score = 0;
    lat_min = 5;
    lat_max = 50;
    rd_rate = 80;
    wr_rate = 70;
    start_job(40);
    wait_done(40);
    chk("t3_lines", lines_written, 3);
    check_ids();

    // held results released together, write stall
    lat_min = 2;
    lat_max = 6;
    rd_rate = 100;
    wr_rate = 0;
    hold = 1;
    start_job(20);
    repeat (60) cycle();
    hold = 0;
    for (int i = 0; i < 800 && records_done != 16; i++)
      cycle();
    repeat (20) cycle();
    chk("t4_stall_count", records_done, 16);
    chk("t4_stall_no_ack", eng_res_ack, 0);
    chk("t4_stall_lines", lines_written, 0);
    wr_rate = 100;
    wait_done(20);
    chk("t4_lines", lines_written, 2);
    check_ids();

    // reset in the middle of a job
    lat_min = 5;
    lat_max = 20;
    wr_rate = 80;
    start_job(40);
    repeat (30) cycle();
    reset = 1'b0;
    cycle();
    model_reset();
    reset = 1'b1;
    check_idle_outputs("midreset");
    start_job(2);
    wait_done(2);
    chk("t5_lines", lines_written, 1);
    check_ids();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
